alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit.sv | 120 ++++++++++++
 tb/tb_alu_exec_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Registered EX stage: single-cycle ALU ops with a bit-serial left shifter,
// valid/ready on both sides so hazard/stall logic can throttle it.
module alu_exec_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             start_shift;
  logic             last_shift;

  assign shamt       = b[SHW-1:0];
  assign accept      = in_valid && in_ready;
  // A zero shift amount is just a copy of a, so it takes the single-cycle path.
  assign start_shift = accept && (aluctr == OP_SLL) && (shamt != '0);
  assign shifted     = work << 1;
  assign last_shift  = (cnt == SHW'(1));

  always_comb begin
    alu_res = '0;
    case (aluctr)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: alu_res = a + b;
      OP_XOR: alu_res = a ^ b;
      OP_NOR: alu_res = ~(a | b);
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SUB: alu_res = a - b;
      OP_SLL: alu_res = a << shamt;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_shift) state_next = SHIFT;
      SHIFT:   if (last_shift)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && (!out_valid || out_ready);
    busy     = (state == SHIFT);
  end

  // Entering SHIFT always leaves out_valid low: either it was already empty
  // or it is being consumed on the same edge as the accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      work      <= '0;
      cnt       <= '0;
    end else if (state == IDLE) begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (start_shift) begin
        work <= a;
        cnt  <= shamt;
      end else if (accept) begin
        result    <= alu_res;
        zero      <= (alu_res == '0);
        out_valid <= 1'b1;
      end
    end else begin
      if (last_shift) begin
        result    <= shifted;
        zero      <= (shifted == '0);
        out_valid <= 1'b1;
      end else begin
        work <= shifted;
        cnt  <= cnt - SHW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed checks of alu_exec_unit followed by a randomized handshake sweep
// against a small reference ALU model.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  aluctr;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  alu_exec_unit #(.WIDTH(16), .SHW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluctr    (aluctr),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for exactly one edge; the stage must be ready for it.
  task automatic issue(input logic [2:0] op, input logic [15:0] aa, input logic [15:0] bb);
    in_valid = 1'b1;
    aluctr   = op;
    a        = aa;
    b        = bb;
    #1;
    check1("in_ready_before_issue", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      3'b000: return x & y;
      3'b001: return x | y;
      3'b010: return x + y;
      3'b011: return x ^ y;
      3'b100: return ~(x | y);
      3'b101: return ($signed(x) < $signed(y)) ? 16'h0001 : 16'h0000;
      3'b110: return x - y;
      default: return x << y[3:0];
    endcase
  endfunction

  initial begin
    logic [15:0] exp_q[$];
    logic [15:0] e;
    int acc_n;
    int cons_n;
    int extra_n;
    int cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    aluctr    = 3'b000;
    a         = 16'h0000;
    b         = 16'h0000;
    out_ready = 1'b1;

    #2;
    check1("rst_out_valid", out_valid, 1'b0);
    check16("rst_result", result, 16'h0000);
    check1("rst_zero", zero, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-cycle ops streamed back to back with out_ready high.
    issue(3'b010, 16'h7FFF, 16'h0001);
    check1("add_valid", out_valid, 1'b1);
    check16("add_result", result, 16'h8000);
    check1("add_zero", zero, 1'b0);
    issue(3'b110, 16'h1234, 16'h1234);
    check16("sub_result", result, 16'h0000);
    check1("sub_zero", zero, 1'b1);
    issue(3'b101, 16'hFFFF, 16'h0001);
    check16("slt_neg_result", result, 16'h0001);
    check1("slt_neg_zero", zero, 1'b0);
    issue(3'b101, 16'h0001, 16'hFFFF);
    check16("slt_pos_result", result, 16'h0000);
    check1("slt_pos_zero", zero, 1'b1);
    issue(3'b100, 16'h00FF, 16'hFF00);
    check16("nor_result", result, 16'h0000);
    check1("nor_zero", zero, 1'b1);
    issue(3'b000, 16'hF0F0, 16'hFF00);
    check16("and_result", result, 16'hF000);
    issue(3'b001, 16'h0F00, 16'h00F0);
    check16("or_result", result, 16'h0FF0);
    issue(3'b011, 16'hFFFF, 16'h00FF);
    check16("xor_result", result, 16'hFF00);
    issue(3'b010, 16'hFFFF, 16'h0002);
    check16("add_wrap_result", result, 16'h0001);
    issue(3'b110, 16'h0000, 16'h0001);
    check16("sub_wrap_result", result, 16'hFFFF);
    tick();
    check1("drain_valid", out_valid, 1'b0);

    // Serial shift by 5: five busy cycles, then the result.
    issue(3'b111, 16'h0001, 16'h0005);
    for (int i = 0; i < 5; i++) begin
      check1("sll5_busy", busy, 1'b1);
      check1("sll5_in_ready", in_ready, 1'b0);
      check1("sll5_out_valid", out_valid, 1'b0);
      tick();
    end
    check1("sll5_done_valid", out_valid, 1'b1);
    check16("sll5_result", result, 16'h0020);
    check1("sll5_done_busy", busy, 1'b0);
    tick();

    // Shift amount 0 (upper b bits ignored) takes the single-cycle path.
    issue(3'b111, 16'hABCD, 16'h0010);
    check1("sll0_busy", busy, 1'b0);
    check1("sll0_valid", out_valid, 1'b1);
    check16("sll0_result", result, 16'hABCD);
    check1("sll0_zero", zero, 1'b0);

    // MSB is discarded on a one-bit shift.
    issue(3'b111, 16'h8001, 16'h0001);
    check1("sll1_busy", busy, 1'b1);
    tick();
    check16("sll1_result", result, 16'h0002);
    check1("sll1_valid", out_valid, 1'b1);
    tick();

    // Backpressure: AND result held for 3 cycles while OR waits.
    in_valid = 1'b1; aluctr = 3'b000; a = 16'hFF0F; b = 16'h0FF0;
    tick();
    check16("bp_first_result", result, 16'h0F00);
    out_ready = 1'b0;
    aluctr = 3'b001; a = 16'h1200; b = 16'h0034;
    for (int i = 0; i < 3; i++) begin
      #1;
      check1("bp_in_ready_low", in_ready, 1'b0);
      tick();
      check1("bp_hold_valid", out_valid, 1'b1);
      check16("bp_hold_result", result, 16'h0F00);
    end
    out_ready = 1'b1;
    tick();
    check16("bp_second_result", result, 16'h1234);
    aluctr = 3'b011; a = 16'hAAAA; b = 16'h5555;
    tick();
    check16("bp_third_result", result, 16'hFFFF);
    check1("bp_third_zero", zero, 1'b0);
    in_valid = 1'b0;
    tick();
    check1("bp_drained", out_valid, 1'b0);

    // Reset during the 2nd SHIFT cycle abandons the shift.
    issue(3'b111, 16'h0003, 16'h0004);
    tick();
    check1("rs_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("rs_out_valid", out_valid, 1'b0);
    check1("rs_busy", busy, 1'b0);
    check16("rs_result", result, 16'h0000);
    check1("rs_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; aluctr = 3'b010; a = 16'h0009; b = 16'h0009;
    tick();
    check1("rs_no_accept", out_valid, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    issue(3'b010, 16'h0002, 16'h0003);
    check1("rs_add_valid", out_valid, 1'b1);
    check16("rs_add_result", result, 16'h0005);
    tick();

    // Random sweep against the reference model.
    acc_n = 0; cons_n = 0; extra_n = 0; cyc = 0;
    while ((acc_n < 300 || exp_q.size() != 0) && cyc < 20000) begin
      in_valid  = (acc_n < 300) && ($urandom_range(0, 3) != 0);
      aluctr    = 3'($urandom_range(0, 7));
      a         = 16'($urandom);
      b         = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_alu(aluctr, a, b));
        acc_n++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          extra_n++;
        end else begin
          e = exp_q.pop_front();
          check16("sweep_result", result, e);
          check1("sweep_zero", zero, (e == 16'h0000));
          cons_n++;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check1("sweep_in_time", (cyc < 20000), 1'b1);
    check_int("sweep_consumed", cons_n, 300);
    check_int("sweep_extra", extra_n, 0);
    check_int("sweep_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
